multi_channel_hms_timer: RTL and testbench

//  NUM_CH independent HH:MM:SS timers sharing one 1 Hz prescaler. Each channel is a countdown timer with an expiry alarm, or a wrapping stopwatch (MODE_UP).
//  One channel at a time is selected for editing and status.

---
 rtl/multi_channel_hms_timer_pkg.sv | 28 ++
 rtl/multi_channel_hms_timer_channel.sv | 109 ++++++++++
 rtl/multi_channel_hms_timer.sv | 95 +++++++++
 tb/tb_multi_channel_hms_timer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_hms_timer_pkg.sv
// Shared types, field widths and set-button codes for the multi-channel HH:MM:SS timer.
package hms_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } tmr_state_t;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  // set_btn bit order is {H+,H-,M+,M-,S+,S-}
  localparam logic [5:0] SET_H_INC = 6'b100000;
  localparam logic [5:0] SET_H_DEC = 6'b010000;
  localparam logic [5:0] SET_M_INC = 6'b001000;
  localparam logic [5:0] SET_M_DEC = 6'b000100;
  localparam logic [5:0] SET_S_INC = 6'b000010;
  localparam logic [5:0] SET_S_DEC = 6'b000001;

  function automatic logic [23:0] pack_hms(input logic [HR_W-1:0]  h,
                                           input logic [MIN_W-1:0] m,
                                           input logic [SEC_W-1:0] s);
    return {3'b000, h, 2'b00, m, 2'b00, s};
  endfunction

endpackage

// File: rtl/multi_channel_hms_timer_channel.sv
// One timer channel: countdown with expiry or wrapping stopwatch, editable while IDLE.
module hms_timer_channel
  import hms_timer_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             mode_up,
  input  logic             run_stb,
  input  logic             clr_lvl,
  input  logic [5:0]       set_stb,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output tmr_state_t       state
);

  localparam logic [HR_W-1:0]  HR_TOP = HR_W'(HOUR_MAX);
  localparam logic [MIN_W-1:0] M_TOP  = MIN_W'(59);
  localparam logic [SEC_W-1:0] S_TOP  = SEC_W'(59);

  logic [HR_W-1:0]  hr_q, hr_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  tmr_state_t       st_q, st_d;
  logic             is_zero;
  logic             set_onehot;

  always_comb begin
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    st_d       = st_q;
    is_zero    = (hr_q == '0) && (min_q == '0) && (sec_q == '0);
    set_onehot = (set_stb != '0) && ((set_stb & (set_stb - 6'd1)) == '0);

    if (clr_lvl) begin
      hr_d  = '0;
      min_d = '0;
      sec_d = '0;
      st_d  = IDLE;
    end else if (run_stb) begin
      case (st_q)
        IDLE:    if (mode_up || !is_zero) st_d = RUN;
        default: st_d = IDLE;
      endcase
    end else if (st_q == IDLE && set_onehot) begin
      case (set_stb)
        SET_H_INC: hr_d  = (hr_q >= HR_TOP) ? '0 : hr_q + HR_W'(1);
        SET_H_DEC: hr_d  = (hr_q == '0) ? HR_TOP : hr_q - HR_W'(1);
        SET_M_INC: min_d = (min_q >= M_TOP) ? '0 : min_q + MIN_W'(1);
        SET_M_DEC: min_d = (min_q == '0) ? M_TOP : min_q - MIN_W'(1);
        SET_S_INC: sec_d = (sec_q >= S_TOP) ? '0 : sec_q + SEC_W'(1);
        SET_S_DEC: sec_d = (sec_q == '0) ? S_TOP : sec_q - SEC_W'(1);
        default: ;
      endcase
    end else if (st_q == RUN && tick) begin
      if (mode_up) begin
        if (sec_q >= S_TOP) begin
          sec_d = '0;
          if (min_q >= M_TOP) begin
            min_d = '0;
            hr_d  = (hr_q >= HR_TOP) ? '0 : hr_q + HR_W'(1);
          end else begin
            min_d = min_q + MIN_W'(1);
          end
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      // Also catches a channel switched to down mode while sitting at zero.
      end else if (hr_q == '0 && min_q == '0 && sec_q <= SEC_W'(1)) begin
        sec_d = '0;
        st_d  = EXPIRED;
      end else if (sec_q != '0) begin
        sec_d = sec_q - SEC_W'(1);
      end else begin
        sec_d = S_TOP;
        if (min_q != '0) begin
          min_d = min_q - MIN_W'(1);
        end else begin
          min_d = M_TOP;
          hr_d  = hr_q - HR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hr_q  <= '0;
      min_q <= '0;
      sec_q <= '0;
      st_q  <= IDLE;
    end else begin
      hr_q  <= hr_d;
      min_q <= min_d;
      sec_q <= sec_d;
      st_q  <= st_d;
    end
  end

  assign hr    = hr_q;
  assign min   = min_q;
  assign sec   = sec_q;
  assign state = st_q;

endmodule

// File: rtl/multi_channel_hms_timer.sv
// NUM_CH HH:MM:SS timers on a shared 1 Hz prescaler with button edge detection and a status mux.
module multi_channel_hms_timer
  import hms_timer_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  TICK_DIV = 50_000_000,
  parameter int  HOUR_MAX = 23,
  localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     ch_sel,
  input  logic [NUM_CH-1:0] mode_up,
  input  logic              run_btn,
  input  logic              clr_btn,
  input  logic [5:0]        set_btn,
  output logic [23:0]       time_bus,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] alarm,
  output logic              alarm_any
);

  localparam int          PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW:0] NUM_CH_W  = (CW + 1)'(NUM_CH);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [5:0]    set_q, set_d;
  logic          tick;
  logic          run_edge;
  logic [5:0]    set_edge;
  logic          sel_valid;

  logic [HR_W-1:0]  hr_w  [NUM_CH];
  logic [MIN_W-1:0] min_w [NUM_CH];
  logic [SEC_W-1:0] sec_w [NUM_CH];
  tmr_state_t       st_w  [NUM_CH];

  always_comb begin
    tick      = (cnt_q == TICK_LAST);
    cnt_d     = tick ? '0 : cnt_q + PW'(1);
    run_d     = run_btn;
    set_d     = set_btn;
    run_edge  = run_btn & ~run_q;
    set_edge  = set_btn & ~set_q;
    sel_valid = ({1'b0, ch_sel} < NUM_CH_W);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      set_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      set_q <= set_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic sel_g;
    assign sel_g = sel_valid && (ch_sel == CW'(gi));

    hms_timer_channel #(
      .HOUR_MAX (HOUR_MAX)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .mode_up (mode_up[gi]),
      .run_stb (sel_g & run_edge),
      .clr_lvl (sel_g & clr_btn),
      .set_stb (sel_g ? set_edge : 6'd0),
      .hr      (hr_w[gi]),
      .min     (min_w[gi]),
      .sec     (sec_w[gi]),
      .state   (st_w[gi])
    );

    assign running[gi] = (st_w[gi] == RUN);
    assign alarm[gi]   = (st_w[gi] == EXPIRED);
  end

  always_comb begin
    time_bus = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_valid && ch_sel == CW'(i)) time_bus = pack_hms(hr_w[i], min_w[i], sec_w[i]);
    end
  end

  assign alarm_any = |alarm;

endmodule

// File: tb/tb_multi_channel_hms_timer.sv
// Directed bench for multi_channel_hms_timer with a 4-cycle tick and four channels.
module tb_multi_channel_hms_timer;
  import hms_timer_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic [3:0]  mode_up = '0;
  logic        run_btn = 1'b0;
  logic        clr_btn = 1'b0;
  logic [5:0]  set_btn = '0;
  logic [23:0] time_bus;
  logic [3:0]  running;
  logic [3:0]  alarm;
  logic        alarm_any;

  int checks = 0;
  int errors = 0;
  int pcnt;

  multi_channel_hms_timer #(
    .NUM_CH   (NUM_CH),
    .TICK_DIV (TICK_DIV),
    .HOUR_MAX (23)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_sel    (ch_sel),
    .mode_up   (mode_up),
    .run_btn   (run_btn),
    .clr_btn   (clr_btn),
    .set_btn   (set_btn),
    .time_bus  (time_bus),
    .running   (running),
    .alarm     (alarm),
    .alarm_any (alarm_any)
  );

  always #5 clk = ~clk;

  // Expected prescaler phase: the tick lands on the edge after pcnt reads TICK_DIV-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) pcnt <= 0;
    else      pcnt <= (pcnt == TICK_DIV - 1) ? 0 : pcnt + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic wait_pcnt(input int v);
    int guard = 0;
    while (pcnt != v) begin
      @(negedge clk);
      guard++;
      if (guard > 4 * TICK_DIV) begin
        errors++;
        $display("FAIL wait_pcnt: phase %0d never reached, expected %0d", pcnt, v);
        $fatal(1, "prescaler phase wait expired");
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      wait_pcnt(TICK_DIV - 1);
      @(negedge clk);
    end
  endtask

  task automatic press_run();
    run_btn = 1'b1;
    @(negedge clk);
    run_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_set(input logic [5:0] code);
    set_btn = code;
    @(negedge clk);
    set_btn = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time 200000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check_value("rst_time_bus", 32'(time_bus), 32'h0);
    check_value("rst_running", 32'(running), 32'h0);
    check_value("rst_alarm", 32'(alarm), 32'h0);
    check_value("rst_alarm_any", 32'(alarm_any), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1. Reset mid-run
    ch_sel = 2'd0;
    for (int i = 0; i < 5; i++) press_set(SET_S_INC);
    check_value("t1_set_5s", 32'(time_bus), 32'h000005);
    wait_pcnt(0);
    press_run();
    check_value("t1_running", 32'(running), 32'h1);
    check_value("t1_time_held", 32'(time_bus), 32'h000005);
    #2;
    rst = 1'b0;
    #1;
    check_value("t1_async_time", 32'(time_bus), 32'h0);
    check_value("t1_async_running", 32'(running), 32'h0);
    check_value("t1_async_alarm_any", 32'(alarm_any), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press_run();
    check_value("t1_run_zero_ignored", 32'(running), 32'h0);

    // 2. Countdown to expiry
    ch_sel = 2'd1;
    press_set(SET_M_INC);
    check_value("t2_set_1m", 32'(time_bus), 32'h000100);
    wait_pcnt(0);
    press_run();
    check_value("t2_running", 32'(running), 32'h2);
    wait_ticks(1);
    check_value("t2_after_1tick", 32'(time_bus), 32'h00003B);
    wait_ticks(59);
    check_value("t2_alarm", 32'(alarm), 32'h2);
    check_value("t2_alarm_any", 32'(alarm_any), 32'h1);
    check_value("t2_expired_time", 32'(time_bus), 32'h0);
    check_value("t2_expired_running", 32'(running), 32'h0);
    wait_ticks(2);
    check_value("t2_expired_holds", 32'(alarm), 32'h2);
    press_run();
    check_value("t2_ack_alarm", 32'(alarm), 32'h0);
    check_value("t2_ack_alarm_any", 32'(alarm_any), 32'h0);
    check_value("t2_ack_running", 32'(running), 32'h0);

    // 3. Edit wraps, no carry, invalid and locked edits
    ch_sel = 2'd2;
    press_set(SET_H_DEC);
    check_value("t3_h_dec_wrap", 32'(time_bus), 32'h170000);
    press_set(SET_M_DEC);
    check_value("t3_m_dec_wrap", 32'(time_bus), 32'h173B00);
    for (int i = 0; i < 60; i++) press_set(SET_S_INC);
    check_value("t3_s_inc_x60", 32'(time_bus), 32'h173B00);
    press_set(6'b000011);
    check_value("t3_not_onehot", 32'(time_bus), 32'h173B00);
    wait_pcnt(0);
    run_btn = 1'b1;
    @(negedge clk);
    run_btn = 1'b0;
    set_btn = SET_S_INC;
    @(negedge clk);
    set_btn = '0;
    check_value("t3_run_started", 32'(running), 32'h4);
    check_value("t3_set_while_run", 32'(time_bus), 32'h173B00);
    press_run();
    check_value("t3_paused", 32'(running), 32'h0);
    check_value("t3_paused_time", 32'(time_bus), 32'h173B00);

    // 4. Stopwatch wrap through midnight
    ch_sel = 2'd3;
    mode_up = 4'b1000;
    press_set(SET_H_DEC);
    press_set(SET_M_DEC);
    press_set(SET_S_DEC);
    press_set(SET_S_DEC);
    check_value("t4_set_235958", 32'(time_bus), 32'h173B3A);
    wait_pcnt(0);
    press_run();
    check_value("t4_running", 32'(running), 32'h8);
    wait_ticks(1);
    check_value("t4_235959", 32'(time_bus), 32'h173B3B);
    wait_ticks(1);
    check_value("t4_wrap_000000", 32'(time_bus), 32'h000000);
    check_value("t4_no_alarm", 32'(alarm), 32'h0);
    check_value("t4_still_running", 32'(running), 32'h8);
    wait_pcnt(0);
    press_run();
    check_value("t4_paused", 32'(running), 32'h0);

    // 5. Independence and clr over run priority
    ch_sel = 2'd1;
    press_set(SET_M_INC);
    ch_sel = 2'd0;
    press_set(SET_M_INC);
    wait_pcnt(0);
    press_run();
    ch_sel = 2'd1;
    wait_pcnt(0);
    press_run();
    ch_sel = 2'd2;
    press_set(SET_S_INC);
    #1;
    check_value("t5_ch2_edit", 32'(time_bus), 32'h173B01);
    check_value("t5_both_running", 32'(running), 32'h3);
    ch_sel = 2'd0;
    #1;
    check_value("t5_ch0_time", 32'(time_bus), 32'h00003A);
    ch_sel = 2'd1;
    #1;
    check_value("t5_ch1_time", 32'(time_bus), 32'h00003B);
    @(negedge clk);
    clr_btn = 1'b1;
    run_btn = 1'b1;
    @(negedge clk);
    clr_btn = 1'b0;
    run_btn = 1'b0;
    check_value("t5_clr_time", 32'(time_bus), 32'h0);
    check_value("t5_clr_running", 32'(running), 32'h1);
    check_value("t5_clr_alarm", 32'(alarm), 32'h0);
    @(negedge clk);

    // 6. Pause on a tick edge, then resume
    ch_sel = 2'd0;
    clr_btn = 1'b1;
    @(negedge clk);
    clr_btn = 1'b0;
    check_value("t6_clr_ch0", 32'(running), 32'h0);
    for (int i = 0; i < 11; i++) press_set(SET_S_INC);
    check_value("t6_set_11s", 32'(time_bus), 32'h00000B);
    wait_pcnt(0);
    press_run();
    wait_ticks(1);
    check_value("t6_at_10s", 32'(time_bus), 32'h00000A);
    wait_pcnt(TICK_DIV - 1);
    run_btn = 1'b1;
    @(negedge clk);
    run_btn = 1'b0;
    check_value("t6_pause_on_tick", 32'(time_bus), 32'h00000A);
    check_value("t6_pause_running", 32'(running), 32'h0);
    @(negedge clk);
    wait_ticks(5);
    check_value("t6_held_5ticks", 32'(time_bus), 32'h00000A);
    press_run();
    check_value("t6_resumed", 32'(running), 32'h1);
    check_value("t6_resume_time", 32'(time_bus), 32'h00000A);
    wait_ticks(1);
    check_value("t6_decrement", 32'(time_bus), 32'h000009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
